// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display fetch always wins, host reads/writes use idle slots.
// Optional macro FB_STALL_CNT_EN adds a saturating host stall counter (stall_cnt, stall_clr).
module vga_fb_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 4,
    parameter bit TEAR_FREE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vblank,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              host_rready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef FB_STALL_CNT_EN
    ,
    input  logic              stall_clr,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD} state_t;

    state_t state;
    logic   write_ok;
    logic   host_fire;

    // Reads ignore vblank; only writes can tear the picture.
    assign write_ok   = !host_we || (TEAR_FREE == 1'b0) || vblank;
    assign host_ready = rst_n && host_valid && (state == IDLE) && !disp_req && write_ok;
    assign host_fire  = host_valid && host_ready;
    assign disp_rdata = ram_rdata;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst_n && disp_req) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr;
        end else if (host_fire) begin
            ram_en    = 1'b1;
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            disp_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            disp_rvalid <= disp_req;
            case (state)
                IDLE: begin
                    if (host_fire && !host_we)
                        state <= RD_WAIT;
                end
                // RAM data for the host read arrives now, even if the display issues this cycle.
                RD_WAIT: begin
                    host_rdata  <= ram_rdata;
                    host_rvalid <= 1'b1;
                    state       <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (host_rready) begin
                        host_rvalid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_clr)
            stall_cnt <= '0;
        else if (host_valid && !host_ready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: behavioural RAM, reference memory image and per-cycle rule checks.
// Build with FB_STALL_CNT_EN defined to also exercise the stall counter.
module tb_vga_fb_arbiter;
    localparam int AW = 8;
    localparam int DW = 4;
    localparam bit TF = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          vblank = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          host_valid = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ready;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          host_rready = 1'b0;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
`ifdef FB_STALL_CNT_EN
    logic          stall_clr = 1'b0;
    logic [15:0]   stall_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;
    bit auto_rr = 1'b0;
    bit rr_man = 1'b0;
    bit done = 1'b0;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] dq [$];
    logic [DW-1:0] hq [$];

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TEAR_FREE(TF)) dut (
        .clk(clk), .rst_n(rst_n), .vblank(vblank),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_rready(host_rready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef FB_STALL_CNT_EN
        , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'((i * 2) ^ (i >> 4));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural synchronous single-port RAM.
    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_we) mem[ram_addr] <= ram_wdata;
                else        ram_rdata <= mem[ram_addr];
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        host_rready = auto_rr ? 1'($urandom_range(0, 1)) : rr_man;
    end

    // Monitor / reference model, evaluated mid-cycle.
    initial begin
        int  cyc = 0;
        int  acc_cyc = 0;
        bit  rd_out = 1'b0;
        bit  prev_disp = 1'b0;
        bit  exp_rv, exp_rdy;
        int  exp_stall = 0;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                dq.delete(); hq.delete();
                rd_out = 1'b0; prev_disp = 1'b0; exp_stall = 0;
                continue;
            end
            chk("disp_rvalid", 32'(disp_rvalid), 32'(prev_disp));
            if (disp_rvalid && dq.size() > 0) chk("disp_rdata", 32'(disp_rdata), 32'(dq.pop_front()));
            exp_rv = rd_out && (cyc >= acc_cyc + 2);
            chk("host_rvalid", 32'(host_rvalid), 32'(exp_rv));
            if (host_rvalid && hq.size() > 0) chk("host_rdata", 32'(host_rdata), 32'(hq[0]));
            exp_rdy = host_valid && !rd_out && !disp_req && (!host_we || !TF || vblank);
            chk("host_ready", 32'(host_ready), 32'(exp_rdy));
            if (disp_req)
                chk("ram_port_disp", 32'({ram_en, ram_we, ram_addr}), 32'({2'b10, disp_addr}));
            else if (exp_rdy)
                chk("ram_port_host", 32'({ram_en, ram_we, ram_addr, ram_wdata}),
                    32'({1'b1, host_we, host_addr, host_wdata}));
            else
                chk("ram_port_idle", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'(0));
`ifdef FB_STALL_CNT_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
            if (stall_clr) exp_stall = 0;
            else if (host_valid && !exp_rdy && exp_stall < 65535) exp_stall++;
`endif
            if (exp_rv && host_rready) begin
                rd_out = 1'b0;
                void'(hq.pop_front());
            end
            if (exp_rdy) begin
                if (host_we) ref_mem[host_addr] = host_wdata;
                else begin
                    hq.push_back(ref_mem[host_addr]);
                    rd_out = 1'b1;
                    acc_cyc = cyc;
                end
            end
            if (disp_req) dq.push_back(ref_mem[disp_addr]);
            prev_disp = disp_req;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic host_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int budget);
        int n = 0;
        host_valid = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        forever begin
            @(negedge clk);
            if (host_ready) break;
            n++;
            if (n > budget) begin
                n_chk++; n_fail++;
                $display("FAIL host_accept_timeout: no accept after %0d cycles, addr 0x%0h", n, a);
                break;
            end
        end
        @(posedge clk); #1;
        host_valid = 1'b0;
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        disp_req = 1'b1; host_valid = 1'b1; host_we = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_disp_rvalid", 32'(disp_rvalid), 32'(0));
        chk("rst_host_rvalid", 32'(host_rvalid), 32'(0));
        chk("rst_host_rdata", 32'(host_rdata), 32'(0));
        chk("rst_ram_en", 32'(ram_en), 32'(0));
        chk("rst_host_ready", 32'(host_ready), 32'(0));
        disp_req = 1'b0; host_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Display read of preloaded cell 5, then async reset pulse mid-cycle.
        disp_req = 1'b1; disp_addr = 8'h05;
        @(posedge clk); #1 disp_req = 1'b0;
        chk("t1_disp_rvalid", 32'(disp_rvalid), 32'(1));
        chk("t1_disp_rdata", 32'(disp_rdata), 32'(4'hA));
        #1 rst_n = 1'b0;
        #1 chk("t1_async_clr", 32'(disp_rvalid), 32'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // Tear-free write stalls until vblank.
        @(posedge clk); #1 vblank = 1'b0;
        fork
            host_txn(1'b1, 8'h10, 4'h3, 100);
            begin
                repeat (4) @(posedge clk);
                #1 vblank = 1'b1;
                #1;
                chk("t2_ready", 32'(host_ready), 32'(1));
                chk("t2_ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'({2'b11, 8'h10, 4'h3}));
            end
        join
        vblank = 1'b0;

        // Host read held 5 cycles, next read accepted right after rready.
        host_txn(1'b0, 8'h10, 4'h0, 100);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h11;
        @(negedge clk); chk("t3_rvalid_wait", 32'(host_rvalid), 32'(0));
        repeat (4) begin
            @(negedge clk);
            chk("t3_rvalid_hold", 32'(host_rvalid), 32'(1));
            chk("t3_rdata_hold", 32'(host_rdata), 32'(4'h3));
            chk("t3_ready_hold", 32'(host_ready), 32'(0));
        end
        @(posedge clk); #1 rr_man = 1'b1;
        @(negedge clk); chk("t3_ready_on_rready", 32'(host_ready), 32'(0));
        @(posedge clk); #1;
        @(negedge clk); chk("t3_ready_after", 32'(host_ready), 32'(1));
        @(posedge clk); #1 host_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Display and host read collide for 3 cycles.
`ifdef FB_STALL_CNT_EN
        stall_clr = 1'b1;
        @(posedge clk); #1 stall_clr = 1'b0;
`endif
        disp_req = 1'b1; disp_addr = 8'h05;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        repeat (3) begin
            @(negedge clk); chk("t4_ready_blocked", 32'(host_ready), 32'(0));
            @(posedge clk); #1 disp_addr = disp_addr + 8'd1;
        end
        disp_req = 1'b0;
        @(negedge clk); chk("t4_ready_free", 32'(host_ready), 32'(1));
`ifdef FB_STALL_CNT_EN
        chk("t4_stall_cnt", 32'(stall_cnt), 32'(3));
`endif
        @(posedge clk); #1 host_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Display reads during RD_WAIT/RD_HOLD do not disturb host data.
        rr_man = 1'b0; vblank = 1'b1;
        host_txn(1'b1, 8'h20, 4'h5, 100);
        host_txn(1'b1, 8'h30, 4'hC, 100);
        vblank = 1'b0;
        host_txn(1'b0, 8'h20, 4'h0, 100);
        disp_req = 1'b1; disp_addr = 8'h30;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_disp_rdata_a", 32'(disp_rdata), 32'(4'hC));
        chk("t5_host_rdata_a", 32'(host_rdata), 32'(4'h5));
        @(posedge clk); #1 disp_req = 1'b0; rr_man = 1'b1;
        @(negedge clk);
        chk("t5_disp_rdata_b", 32'(disp_rdata), 32'(4'hC));
        chk("t5_host_rdata_b", 32'(host_rdata), 32'(4'h5));
        @(posedge clk); #1;

        // Reset during RD_WAIT drops the read.
        host_txn(1'b0, 8'h20, 4'h0, 100);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk); chk("rst_drop_rvalid", 32'(host_rvalid), 32'(0));
        end
        @(posedge clk); #1;

`ifdef FB_STALL_CNT_EN
        // Long stall saturates the counter; clear wins over increment.
        vblank = 1'b0;
        fork
            host_txn(1'b1, 8'h40, 4'h7, 70000);
            begin
                repeat (65540) @(posedge clk);
                @(negedge clk); chk("t6_saturate", 32'(stall_cnt), 32'(16'hFFFF));
                @(posedge clk); #1 stall_clr = 1'b1;
                @(posedge clk); #1 stall_clr = 1'b0;
                @(negedge clk); chk("t6_clear", 32'(stall_cnt), 32'(0));
                @(posedge clk); #1 vblank = 1'b1;
            end
        join
        vblank = 1'b0;
`endif

        // Randomized traffic on a small address window.
        auto_rr = 1'b1;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    @(posedge clk); #1;
                    host_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                             DW'($urandom_range(0, 15)), 3000);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    disp_req  = ($urandom_range(0, 99) < 40);
                    disp_addr = AW'($urandom_range(0, 15));
                    if ($urandom_range(0, 99) < 4) vblank = !vblank;
`ifdef FB_STALL_CNT_EN
                    stall_clr = ($urandom_range(0, 99) < 2);
`endif
                end
                disp_req = 1'b0;
`ifdef FB_STALL_CNT_EN
                stall_clr = 1'b0;
`endif
            end
        join

        repeat (20) @(posedge clk);
        #1;
        chk("drain_host_q", hq.size(), 0);
        chk("drain_disp_q", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
